// File: rtl/gpio_interrupt_controller.sv
// rtl/gpio_interrupt_controller.sv - GPIO edge-detect interrupt controller; optional per-pin debounce via GPIO_DEBOUNCE_EN
module gpio_interrupt_controller #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0,
    parameter int          NUM_PINS        = 8,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_en,
    input  logic                read_en,
    input  logic [31:0]         address,
    input  logic [31:0]         write_data,
    output logic [31:0]         read_data,
    input  logic [NUM_PINS-1:0] gpio_in,
    output logic                interrupt_req
);
    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_ARM    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [31:0] ADDR_MASK   = BASE_ADDRESS;
    localparam logic [31:0] ADDR_RISE   = BASE_ADDRESS + 32'd4;
    localparam logic [31:0] ADDR_FALL   = BASE_ADDRESS + 32'd8;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDRESS + 32'd12;
    localparam logic [31:0] ADDR_LEVEL  = BASE_ADDRESS + 32'd16;

    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync;
    logic [NUM_PINS-1:0] r_prev;
    logic [NUM_PINS-1:0] r_mask;
    logic [NUM_PINS-1:0] r_rise_en;
    logic [NUM_PINS-1:0] r_fall_en;
    logic [NUM_PINS-1:0] r_status;
    logic [31:0]         r_read_data;
    logic                r_irq;
    logic [1:0]          r_state;
    logic [1:0]          r_arm_cnt;

    logic [NUM_PINS-1:0] w_filt;
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_fall;
    logic [NUM_PINS-1:0] w_clr;
    logic                w_capture_en;
    logic [31:0]         w_rd_val;
    logic                w_unused_wdata;

    assign w_unused_wdata = ^write_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync  <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync  <= r_sync1;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0]       r_db_cnt [NUM_PINS];
    logic [NUM_PINS-1:0] r_filt;

    // Level is accepted only after sync has disagreed with filt for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= '0;
            for (int i = 0; i < NUM_PINS; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PINS; i++) begin
                if (r_sync[i] == r_filt[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i]   <= r_sync[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end
    assign w_filt = r_filt;
`else
    assign w_filt = r_sync;
`endif

    // Edges are ignored until the synchronizer has settled after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RESET;
            r_arm_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_RESET: begin
                    r_state   <= ST_ARM;
                    r_arm_cnt <= 2'd0;
                end
                ST_ARM: begin
                    if (r_arm_cnt == 2'd2) r_state <= ST_ACTIVE;
                    else                   r_arm_cnt <= r_arm_cnt + 2'd1;
                end
                ST_ACTIVE: r_state <= ST_ACTIVE;
                default:   r_state <= ST_RESET;
            endcase
        end
    end

    assign w_capture_en = (r_state == ST_ACTIVE);
    assign w_rise = w_filt & ~r_prev & r_rise_en & {NUM_PINS{w_capture_en}};
    assign w_fall = ~w_filt & r_prev & r_fall_en & {NUM_PINS{w_capture_en}};
    assign w_clr  = (write_en && address == ADDR_STATUS) ? write_data[NUM_PINS-1:0] : '0;

    always_comb begin
        w_rd_val = '0;
        if (address == ADDR_MASK)   w_rd_val[NUM_PINS-1:0] = r_mask;
        if (address == ADDR_RISE)   w_rd_val[NUM_PINS-1:0] = r_rise_en;
        if (address == ADDR_FALL)   w_rd_val[NUM_PINS-1:0] = r_fall_en;
        if (address == ADDR_STATUS) w_rd_val[NUM_PINS-1:0] = r_status;
        if (address == ADDR_LEVEL)  w_rd_val[NUM_PINS-1:0] = w_filt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev      <= '0;
            r_mask      <= '0;
            r_rise_en   <= '0;
            r_fall_en   <= '0;
            r_status    <= '0;
            r_read_data <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_prev   <= w_filt;
            // A new edge on a bit being cleared in the same cycle keeps the bit set
            r_status <= (r_status & ~w_clr) | w_rise | w_fall;
            r_irq    <= |(r_status & r_mask);
            if (read_en) r_read_data <= w_rd_val;
            if (write_en && address == ADDR_MASK) r_mask    <= write_data[NUM_PINS-1:0];
            if (write_en && address == ADDR_RISE) r_rise_en <= write_data[NUM_PINS-1:0];
            if (write_en && address == ADDR_FALL) r_fall_en <= write_data[NUM_PINS-1:0];
        end
    end

    assign read_data     = r_read_data;
    assign interrupt_req = r_irq;
endmodule

// File: tb/tb_gpio_interrupt_controller.sv
// tb/tb_gpio_interrupt_controller.sv - randomized self-checking bench for gpio_interrupt_controller
module tb_gpio_interrupt_controller;
    localparam int DB = 16;
`ifdef GPIO_DEBOUNCE_EN
    localparam int LAT = DB;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [7:0]  gpio_in = '0;
    logic        interrupt_req;

    gpio_interrupt_controller #(
        .BASE_ADDRESS(32'h0), .NUM_PINS(8), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .gpio_in(gpio_in), .interrupt_req(interrupt_req)
    );

    always #5 clk = ~clk;

    int n_compared = 0;
    int n_mismatch = 0;

    // Reference state: register contents plus a short history of the filtered pin level
    logic [7:0]  m_mask, m_rise, m_fall, m_status, m_level, m_level_prev, m_pin_last, m_sync;
    logic [31:0] m_read;
    logic        m_irq;
    int          m_edges;
    int          m_dcnt [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mask = 0; m_rise = 0; m_fall = 0; m_status = 0;
        m_level = 0; m_level_prev = 0; m_pin_last = 0; m_sync = 0;
        m_read = 0; m_irq = 0; m_edges = 0;
        for (int i = 0; i < 8; i++) m_dcnt[i] = 0;
    endtask

    function automatic logic [31:0] model_reg(input logic [31:0] a);
        case (a)
            32'd0:   return {24'd0, m_mask};
            32'd4:   return {24'd0, m_rise};
            32'd8:   return {24'd0, m_fall};
            32'd12:  return {24'd0, m_status};
            32'd16:  return {24'd0, m_level};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge: uses register values and pin history as they stood before the edge
    task automatic model_edge();
        logic [7:0] clr, ev;
        clr = (write_en && address == 32'd12) ? write_data[7:0] : 8'd0;
        ev  = 8'd0;
        if (m_edges >= 4)
            ev = (m_level & ~m_level_prev & m_rise) | (~m_level & m_level_prev & m_fall);
        if (read_en) m_read = model_reg(address);
        m_irq    = |(m_status & m_mask);
        m_status = (m_status & ~clr) | ev;
        if (write_en && address == 32'd0) m_mask = write_data[7:0];
        if (write_en && address == 32'd4) m_rise = write_data[7:0];
        if (write_en && address == 32'd8) m_fall = write_data[7:0];
        m_level_prev = m_level;
`ifdef GPIO_DEBOUNCE_EN
        for (int i = 0; i < 8; i++) begin
            if (m_sync[i] != m_level[i]) begin
                m_dcnt[i]++;
                if (m_dcnt[i] == DB) begin
                    m_level[i] = m_sync[i];
                    m_dcnt[i]  = 0;
                end
            end else begin
                m_dcnt[i] = 0;
            end
        end
        m_sync = m_pin_last;
`else
        m_level = m_pin_last;
`endif
        m_pin_last = gpio_in;
        m_edges++;
    endtask

    task automatic cycle();
        logic was_read;
        @(posedge clk);
        was_read = read_en;
        model_edge();
        @(negedge clk);
        check_eq("irq", {31'd0, interrupt_req}, {31'd0, m_irq});
        if (was_read) check_eq("rdata", read_data, m_read);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        write_en = 1'b1; address = a; write_data = d;
        cycle();
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a);
        read_en = 1'b1; address = a;
        cycle();
        read_en = 1'b0;
    endtask

    task automatic do_reset(input logic [7:0] g);
        @(negedge clk);
        reset = 1'b1; gpio_in = g; write_en = 0; read_en = 0;
        #1;
        model_reset();
        check_eq("rst_irq", {31'd0, interrupt_req}, 32'd0);
        check_eq("rst_rdata", read_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();

        // Pins high through reset: arming must hide the startup edge
        do_reset(8'hFF);
        bus_write(32'd4, 32'hFF);
        bus_write(32'd8, 32'hFF);
        bus_write(32'd0, 32'hFF);
        repeat (20) cycle();
`ifndef GPIO_DEBOUNCE_EN
        bus_read(32'd12);
        check_eq("arm_status", read_data, 32'd0);
        check_eq("arm_irq", {31'd0, interrupt_req}, 32'd0);
`endif
        bus_read(32'd16);
        check_eq("arm_level", read_data, 32'hFF);

        // Rising edge latency and W1C clear
        do_reset(8'h00);
        repeat (6) cycle();
        bus_write(32'd4, 32'h01);
        bus_write(32'd0, 32'h01);
        gpio_in[0] = 1'b1;
        repeat (3 + LAT) cycle();
        check_eq("rise_irq_early", {31'd0, interrupt_req}, 32'd0);
        cycle();
        check_eq("rise_irq", {31'd0, interrupt_req}, 32'd1);
        bus_read(32'd12);
        check_eq("rise_status", read_data, 32'h01);
        bus_write(32'd12, 32'h01);
        cycle();
        check_eq("clr_irq", {31'd0, interrupt_req}, 32'd0);

        // Masked falling edge is still captured
        bus_write(32'd4, 32'h00);
        bus_write(32'd0, 32'h00);
        bus_write(32'd8, 32'h80);
        gpio_in[7] = 1'b1;
        repeat (4 + LAT) cycle();
        gpio_in[7] = 1'b0;
        repeat (4 + LAT) cycle();
        check_eq("mask_irq_off", {31'd0, interrupt_req}, 32'd0);
        bus_read(32'd12);
        check_eq("mask_status", read_data, 32'h80);
        bus_write(32'd0, 32'h80);
        cycle();
        check_eq("mask_irq_on", {31'd0, interrupt_req}, 32'd1);

        // Set and clear of the same bit in one cycle: set wins
        bus_write(32'd12, 32'hFF);
        bus_write(32'd0, 32'h00);
        bus_write(32'd8, 32'h00);
        bus_write(32'd4, 32'h04);
        gpio_in[2] = 1'b1;
        repeat (2 + LAT) cycle();
        bus_write(32'd12, 32'h04);
        bus_read(32'd12);
        check_eq("setclr_bit2", read_data & 32'h4, 32'h4);

`ifdef GPIO_DEBOUNCE_EN
        bus_write(32'd12, 32'hFF);
        bus_write(32'd4, 32'h08);
        gpio_in[3] = 1'b1;
        repeat (10) cycle();
        gpio_in[3] = 1'b0;
        repeat (40) cycle();
        bus_read(32'd12);
        check_eq("db_short", read_data & 32'h8, 32'h0);
        gpio_in[3] = 1'b1;
        repeat (30) cycle();
        gpio_in[3] = 1'b0;
        repeat (40) cycle();
        bus_read(32'd12);
        check_eq("db_long", read_data & 32'h8, 32'h8);
`endif

        // Unmapped address
        bus_write(32'd20, 32'hFFFF_FFFF);
        bus_read(32'd20);
        check_eq("unmapped_rd", read_data, 32'd0);
        for (int a = 0; a <= 16; a += 4) bus_read(32'(a));

        // Random pins and bus traffic, with one reset in the middle
        do_reset(8'($urandom));
        for (int i = 0; i < 900; i++) begin
            if (i == 450) do_reset(8'($urandom));
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 8'($urandom);
            address = 32'(4 * $urandom_range(0, 6));
            write_data = $urandom;
            case ($urandom_range(0, 3))
                0: write_en = 1'b1;
                1, 2: read_en = 1'b1;
                default: ;
            endcase
            cycle();
            write_en = 1'b0;
            read_en  = 1'b0;
        end
        for (int a = 0; a <= 16; a += 4) bus_read(32'(a));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end
endmodule
